sym_err_meter: RTL and testbench

SYM_ERR_METER -- requirements
Module: sym_err_meter

---
 rtl/sym_err_meter.sv | 234 +++++++++++++++++++++++
 tb/tb_sym_err_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sym_err_meter.sv
// Symbol error meter: compares rx symbols against delayed tx symbols and latches per-window counts.
// Optional macro SYM_ERR_FIRST_IDX_EN adds first-error-index tracking within each window.
module sym_err_meter #(
  parameter int SYM_W = 2,
  parameter int DELAY = 3,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             arm,
  input  logic             window,
  input  logic [SYM_W-1:0] tx_sym_i,
  input  logic [SYM_W-1:0] tx_sym_q,
  input  logic [SYM_W-1:0] rx_sym_i,
  input  logic [SYM_W-1:0] rx_sym_q,
  output logic [CNT_W-1:0] err_cnt_i,
  output logic [CNT_W-1:0] err_cnt_q,
  output logic [CNT_W-1:0] sym_cnt,
  output logic             sat,
  output logic             done,
  output logic             busy,
  output logic             err_now,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_MEAS  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Saturating increment; the extra MSB flags an increment that hit the ceiling.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
    logic [CNT_W:0] res;
    if (inc && (val == CNT_MAX)) begin
      res = {1'b1, val};
    end else begin
      res = {1'b0, val + {{(CNT_W-1){1'b0}}, inc}};
    end
    return res;
  endfunction

  logic [SYM_W-1:0] tx_dly_i_s;
  logic [SYM_W-1:0] tx_dly_q_s;
  logic             mism_i_s;
  logic             mism_q_s;
  logic             mism_any_s;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_sym_q, acc_sym_d;
  logic [CNT_W-1:0] acc_ei_q, acc_ei_d;
  logic [CNT_W-1:0] acc_eq_q, acc_eq_d;
  logic             ovf_q, ovf_d;
  logic             load_s, inc_s, latch_s;
  logic [CNT_W:0]   sum_sym_s, sum_ei_s, sum_eq_s;

  logic [CNT_W-1:0] err_cnt_i_q, err_cnt_q_q, sym_cnt_q;
  logic             sat_q, done_q, busy_q, err_now_q;

  generate
    if (DELAY == 0) begin : g_nodly
      assign tx_dly_i_s = tx_sym_i;
      assign tx_dly_q_s = tx_sym_q;
    end else begin : g_dly
      logic [SYM_W-1:0] dlyi_q [DELAY];
      logic [SYM_W-1:0] dlyq_q [DELAY];

      // tx alignment shift register, one stage per symbol beat
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < DELAY; k++) begin
            dlyi_q[k] <= {SYM_W{1'b0}};
            dlyq_q[k] <= {SYM_W{1'b0}};
          end
        end else if (clk_en) begin
          dlyi_q[0] <= tx_sym_i;
          dlyq_q[0] <= tx_sym_q;
          for (int k = 1; k < DELAY; k++) begin
            dlyi_q[k] <= dlyi_q[k-1];
            dlyq_q[k] <= dlyq_q[k-1];
          end
        end
      end

      assign tx_dly_i_s = dlyi_q[DELAY-1];
      assign tx_dly_q_s = dlyq_q[DELAY-1];
    end
  endgenerate

  assign mism_i_s   = (rx_sym_i != tx_dly_i_s);
  assign mism_q_s   = (rx_sym_q != tx_dly_q_s);
  assign mism_any_s = mism_i_s | mism_q_s;

  assign sum_sym_s = sat_inc(acc_sym_q, 1'b1);
  assign sum_ei_s  = sat_inc(acc_ei_q, mism_i_s);
  assign sum_eq_s  = sat_inc(acc_eq_q, mism_q_s);

  // FSM next state; arm low wins over window
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    inc_s   = 1'b0;
    latch_s = 1'b0;
    if (clk_en) begin
      if (!arm) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_ARMED;
          ST_ARMED: begin
            if (window) begin
              state_d = ST_MEAS;
              load_s  = 1'b1;
            end else begin
              state_d = ST_ARMED;
            end
          end
          ST_MEAS: begin
            if (window) begin
              latch_s = 1'b1;
              load_s  = 1'b1;
            end else begin
              inc_s = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Accumulator next state: reload on window start, saturating count otherwise
  always_comb begin
    acc_sym_d = acc_sym_q;
    acc_ei_d  = acc_ei_q;
    acc_eq_d  = acc_eq_q;
    ovf_d     = ovf_q;
    if (load_s) begin
      acc_sym_d = CNT_ONE;
      acc_ei_d  = {{(CNT_W-1){1'b0}}, mism_i_s};
      acc_eq_d  = {{(CNT_W-1){1'b0}}, mism_q_s};
      ovf_d     = 1'b0;
    end else if (inc_s) begin
      acc_sym_d = sum_sym_s[CNT_W-1:0];
      acc_ei_d  = sum_ei_s[CNT_W-1:0];
      acc_eq_d  = sum_eq_s[CNT_W-1:0];
      ovf_d     = ovf_q | sum_sym_s[CNT_W] | sum_ei_s[CNT_W] | sum_eq_s[CNT_W];
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State, accumulators and latched results; done is a single-clk pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_sym_q   <= CNT_ZERO;
      acc_ei_q    <= CNT_ZERO;
      acc_eq_q    <= CNT_ZERO;
      ovf_q       <= 1'b0;
      err_cnt_i_q <= CNT_ZERO;
      err_cnt_q_q <= CNT_ZERO;
      sym_cnt_q   <= CNT_ZERO;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_now_q   <= 1'b0;
    end else begin
      done_q <= latch_s;
      if (clk_en) begin
        state_q   <= state_d;
        busy_q    <= (state_d != ST_IDLE);
        err_now_q <= mism_any_s;
        acc_sym_q <= acc_sym_d;
        acc_ei_q  <= acc_ei_d;
        acc_eq_q  <= acc_eq_d;
        ovf_q     <= ovf_d;
        if (latch_s) begin
          sym_cnt_q   <= acc_sym_q;
          err_cnt_i_q <= acc_ei_q;
          err_cnt_q_q <= acc_eq_q;
          sat_q       <= ovf_q;
        end
      end
    end
  end

`ifdef SYM_ERR_FIRST_IDX_EN
  logic [CNT_W-1:0] first_q, first_d, first_out_q;

  // All-ones means no error seen yet in this window
  always_comb begin
    first_d = first_q;
    if (load_s) begin
      first_d = mism_any_s ? CNT_ZERO : CNT_MAX;
    end else if (inc_s && (first_q == CNT_MAX) && mism_any_s) begin
      first_d = acc_sym_q;
    end else begin
      first_d = first_q;
    end
  end

  // First-error index tracking and latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q     <= CNT_MAX;
      first_out_q <= CNT_MAX;
    end else if (clk_en) begin
      first_q <= first_d;
      if (latch_s) begin
        first_out_q <= first_q;
      end
    end
  end

  assign first_err_idx = first_out_q;
`else
  assign first_err_idx = CNT_ZERO;
`endif

  assign err_cnt_i = err_cnt_i_q;
  assign err_cnt_q = err_cnt_q_q;
  assign sym_cnt   = sym_cnt_q;
  assign sat       = sat_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err_now   = err_now_q;

endmodule

// File: tb/tb_sym_err_meter.sv
// Scoreboard bench for sym_err_meter (DELAY=3, CNT_W=8): expected window results queued at drive time.
module tb_sym_err_meter;

  localparam int SYM_W = 2;
  localparam int DELAY = 3;
  localparam int CNT_W = 8;

`ifdef SYM_ERR_FIRST_IDX_EN
  localparam logic [7:0] FI_RST = 8'hFF;
`else
  localparam logic [7:0] FI_RST = 8'h00;
`endif

  logic clk, reset, clk_en, arm, window;
  logic [SYM_W-1:0] tx_sym_i, tx_sym_q, rx_sym_i, rx_sym_q;
  logic [CNT_W-1:0] err_cnt_i, err_cnt_q, sym_cnt, first_err_idx;
  logic sat, done, busy, err_now;

  sym_err_meter #(.SYM_W(SYM_W), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .arm(arm), .window(window),
    .tx_sym_i(tx_sym_i), .tx_sym_q(tx_sym_q), .rx_sym_i(rx_sym_i), .rx_sym_q(rx_sym_q),
    .err_cnt_i(err_cnt_i), .err_cnt_q(err_cnt_q), .sym_cnt(sym_cnt), .sat(sat),
    .done(done), .busy(busy), .err_now(err_now), .first_err_idx(first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] ei;
    logic [7:0] eq;
    logic [7:0] fi;
    logic       sat;
  } res_t;

  res_t sb[$];
  res_t last;
  logic [SYM_W-1:0] tqi[$];
  logic [SYM_W-1:0] tqq[$];
  int m_state, m_sym, m_ei, m_eq, m_first;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input int v);
    logic [31:0] t;
    t = v;
    return (v > 255) ? 8'hFF : t[7:0];
  endfunction

  task automatic model_reset();
    tqi = {2'b00, 2'b00, 2'b00};
    tqq = {2'b00, 2'b00, 2'b00};
    m_state = 0; m_sym = 0; m_ei = 0; m_eq = 0; m_first = -1;
    last = '{s: 8'h00, ei: 8'h00, eq: 8'h00, fi: FI_RST, sat: 1'b0};
  endtask

  task automatic model_load(input logic [1:0] mi, input logic [1:0] mq);
    m_sym = 1;
    m_ei = (mi != 2'b00) ? 1 : 0;
    m_eq = (mq != 2'b00) ? 1 : 0;
    m_first = ((mi | mq) != 2'b00) ? 0 : -1;
  endtask

  task automatic check_held();
    check("sym_cnt", sym_cnt, last.s);
    check("err_cnt_i", err_cnt_i, last.ei);
    check("err_cnt_q", err_cnt_q, last.eq);
    check("sat", sat, last.sat);
    check("first_err_idx", first_err_idx, last.fi);
  endtask

  // One symbol beat (clk_en high for one clk), then 'gap' clocks with clk_en low.
  task automatic beat(input logic a, input logic w, input logic [1:0] mi, input logic [1:0] mq, input int gap);
    logic [1:0] txi, txq;
    logic exp_latch;
    res_t r;
    res_t got;
    txi = 2'($urandom_range(0, 3));
    txq = 2'($urandom_range(0, 3));
    arm = a; window = w; clk_en = 1'b1;
    tx_sym_i = txi; tx_sym_q = txq;
    rx_sym_i = tqi[0] ^ mi;
    rx_sym_q = tqq[0] ^ mq;
    exp_latch = 1'b0;
    if (!a) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (w) begin m_state = 2; model_load(mi, mq); end
        default: begin
          if (w) begin
            r.s = sat8(m_sym); r.ei = sat8(m_ei); r.eq = sat8(m_eq);
            r.sat = (m_sym > 255) || (m_ei > 255) || (m_eq > 255);
`ifdef SYM_ERR_FIRST_IDX_EN
            r.fi = (m_first < 0) ? 8'hFF : sat8(m_first);
`else
            r.fi = 8'h00;
`endif
            sb.push_back(r);
            last = r;
            exp_latch = 1'b1;
            model_load(mi, mq);
          end else begin
            if (m_first < 0 && (mi | mq) != 2'b00) m_first = m_sym;
            m_sym++;
            if (mi != 2'b00) m_ei++;
            if (mq != 2'b00) m_eq++;
          end
        end
      endcase
    end
    @(posedge clk); #1;
    void'(tqi.pop_front()); tqi.push_back(txi);
    void'(tqq.pop_front()); tqq.push_back(txq);
    clk_en = 1'b0;
    check("done", done, exp_latch);
    if (done) begin
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        got = sb.pop_front();
        check("sb_sym_cnt", sym_cnt, got.s);
        check("sb_err_cnt_i", err_cnt_i, got.ei);
        check("sb_err_cnt_q", err_cnt_q, got.eq);
        check("sb_sat", sat, got.sat);
        check("sb_first_err_idx", first_err_idx, got.fi);
      end
    end
    check("busy", busy, (m_state != 0));
    check("err_now", err_now, ((mi | mq) != 2'b00));
    check_held();
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("done_gap", done, 1'b0);
    end
  endtask

  // mode 0 clean, 1 Q errors at beats 5/40, 2 all I wrong, 3 sparse random errors
  task automatic run_window(input int len, input int mode, input int gap);
    logic [1:0] mi, mq;
    for (int i = 0; i < len; i++) begin
      mi = 2'b00; mq = 2'b00;
      case (mode)
        1: if (i == 5 || i == 40) mq = 2'b10;
        2: mi = 2'b01;
        3: if ($urandom_range(0, 9) == 0) begin
             mi = 2'($urandom_range(0, 3));
             mq = 2'($urandom_range(0, 1));
           end
        default: mi = 2'b00;
      endcase
      beat(1'b1, (i == 0), mi, mq, gap);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sym_cnt"}, sym_cnt, 8'h00);
    check({tag, "_err_cnt_i"}, err_cnt_i, 8'h00);
    check({tag, "_err_cnt_q"}, err_cnt_q, 8'h00);
    check({tag, "_sat"}, sat, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err_now"}, err_now, 1'b0);
    check({tag, "_first_err_idx"}, first_err_idx, FI_RST);
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; arm = 1'b0; window = 1'b0;
    tx_sym_i = 2'b00; tx_sym_q = 2'b00; rx_sym_i = 2'b00; rx_sym_q = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    run_window(100, 0, 0);
    run_window(100, 0, 1);
    run_window(100, 1, 0);
    run_window(80, 3, 0);
    run_window(300, 2, 0);
    run_window(50, 0, 2);
    run_window(60, 0, 0);
    // partial window abandoned by dropping arm
    run_window(50, 0, 0);
    beat(1'b0, 1'b0, 2'b00, 2'b00, 0);
    beat(1'b0, 1'b1, 2'b00, 2'b00, 0);

    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    run_window(30, 3, 0);
    beat(1'b0, 1'b1, 2'b00, 2'b00, 0);
    beat(1'b0, 1'b0, 2'b00, 2'b00, 0);

    // async reset mid-window, asserted between clock edges
    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    run_window(20, 1, 0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    sb.delete();
    #3 reset = 1'b0;
    @(posedge clk); #1;
    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);
    run_window(40, 1, 0);
    beat(1'b1, 1'b1, 2'b00, 2'b00, 0);
    beat(1'b1, 1'b0, 2'b00, 2'b00, 0);

    check("sb_leftover", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
